// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and the memory-master state encoding.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdResp,
        StRsp
    } axil_mst_state_t;

    // SLVERR and DECERR both have bit 1 set
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/axil_mem_master.sv
// AXI4-Lite initiator: turns single-request memory accesses into AXI4-Lite transactions,
// one outstanding at a time, returning data and the AXI response code.
module axil_mem_master
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_err,
    output logic [7:0]            err_count,

    output logic [ADDR_WIDTH-1:0] axi_awaddr,
    output logic                  axi_awvalid,
    input  logic                  axi_awready,
    output logic [DATA_WIDTH-1:0] axi_wdata,
    output logic [STRB_WIDTH-1:0] axi_wstrb,
    output logic                  axi_wvalid,
    input  logic                  axi_wready,
    input  logic [1:0]            axi_bresp,
    input  logic                  axi_bvalid,
    output logic                  axi_bready,
    output logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    input  logic [DATA_WIDTH-1:0] axi_rdata,
    input  logic [1:0]            axi_rresp,
    input  logic                  axi_rvalid,
    output logic                  axi_rready
);

    axil_mst_state_t       state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            resp_q, resp_d;
    logic [7:0]            err_q, err_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
        err_d       = err_q;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        axi_bready  = 1'b0;
        axi_arvalid = 1'b0;
        axi_rready  = 1'b0;

        case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_we ? StWrReq : StRdReq;
                end
            end
            StWrReq: begin
                // AW and W complete independently; each valid drops once its own handshake is seen
                axi_awvalid = !aw_done_q;
                axi_wvalid  = !w_done_q;
                if (axi_awvalid && axi_awready) aw_done_d = 1'b1;
                if (axi_wvalid && axi_wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)      state_d   = StWrResp;
            end
            StWrResp: begin
                axi_bready = 1'b1;
                if (axi_bvalid) begin
                    resp_d  = axi_bresp;
                    rdata_d = '0;
                    state_d = StRsp;
                    if (resp_is_err(axi_bresp) && err_q != 8'hff) err_d = err_q + 8'd1;
                end
            end
            StRdReq: begin
                axi_arvalid = 1'b1;
                if (axi_arready) state_d = StRdResp;
            end
            StRdResp: begin
                axi_rready = 1'b1;
                if (axi_rvalid) begin
                    resp_d  = axi_rresp;
                    rdata_d = axi_rdata;
                    state_d = StRsp;
                    if (resp_is_err(axi_rresp) && err_q != 8'hff) err_d = err_q + 8'd1;
                end
            end
            StRsp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign axi_awaddr = addr_q;
    assign axi_araddr = addr_q;
    assign axi_wdata  = wdata_q;
    assign axi_wstrb  = wstrb_q;
    assign rsp_rdata  = rdata_q;
    assign rsp_resp   = resp_q;
    assign rsp_err    = resp_q[1];
    assign err_count  = err_q;

endmodule

// File: tb/tb_axil_mem_master.sv
// Directed bench for axil_mem_master against a small AXI-Lite RAM responder
// mapped at 0x400-0xFFF (SLVERR elsewhere).
module tb_axil_mem_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  err_count;
    logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
    logic [3:0]  axi_wstrb;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
    logic [1:0]  axi_bresp, axi_rresp;
    logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready, axi_rvalid, axi_rready;

    always #5 clk = ~clk;

    axil_mem_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_err(rsp_err), .err_count(err_count),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready), .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    // ---------------- responder model ----------------
    int          cyc = 0;
    int          aw_delay = 0;
    logic        rd_stall = 1'b0;
    logic [31:0] mem [0:1023];
    int          aw_wait, aw_hs_cyc, w_hs_cyc, ar_hs_cyc, wr_count;
    logic        aw_got, w_got;
    logic [31:0] aw_a, w_d;
    logic [3:0]  w_s;

    assign axi_awready = axi_awvalid && !aw_got && (aw_wait >= aw_delay);
    assign axi_wready  = axi_wvalid && !w_got;
    assign axi_arready = axi_arvalid && !axi_rvalid;

    always_ff @(posedge clk) cyc <= cyc + 1;

    always_ff @(posedge clk) begin
        logic        aw_now, w_now;
        logic [31:0] a, d;
        logic [3:0]  s;
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
            aw_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            axi_bvalid <= 1'b0; axi_bresp <= 2'b00;
            axi_rvalid <= 1'b0; axi_rresp <= 2'b00; axi_rdata <= '0;
            aw_hs_cyc <= -1; w_hs_cyc <= -1; ar_hs_cyc <= -1; wr_count <= 0;
        end else begin
            aw_now = axi_awvalid && axi_awready;
            w_now  = axi_wvalid && axi_wready;
            if (aw_now) begin
                aw_got <= 1'b1; aw_a <= axi_awaddr; aw_hs_cyc <= cyc; aw_wait <= 0;
            end else if (axi_awvalid) begin
                aw_wait <= aw_wait + 1;
            end
            if (w_now) begin
                w_got <= 1'b1; w_d <= axi_wdata; w_s <= axi_wstrb; w_hs_cyc <= cyc;
            end
            if (axi_bvalid && axi_bready) axi_bvalid <= 1'b0;
            if ((aw_got || aw_now) && (w_got || w_now)) begin
                a = aw_got ? aw_a : axi_awaddr;
                d = w_got ? w_d : axi_wdata;
                s = w_got ? w_s : axi_wstrb;
                aw_got <= 1'b0; w_got <= 1'b0;
                axi_bvalid <= 1'b1;
                wr_count <= wr_count + 1;
                if (a >= 32'h400 && a <= 32'hfff) begin
                    axi_bresp <= 2'b00;
                    for (int b = 0; b < 4; b++)
                        if (s[b]) mem[a[11:2]][8*b +: 8] <= d[8*b +: 8];
                end else begin
                    axi_bresp <= 2'b10;
                end
            end
            if (axi_rvalid && axi_rready) axi_rvalid <= 1'b0;
            if (axi_arvalid && axi_arready) begin
                ar_hs_cyc <= cyc;
                if (!rd_stall) begin
                    axi_rvalid <= 1'b1;
                    if (axi_araddr >= 32'h400 && axi_araddr <= 32'hfff) begin
                        axi_rdata <= mem[axi_araddr[11:2]]; axi_rresp <= 2'b00;
                    end else begin
                        axi_rdata <= '0; axi_rresp <= 2'b10;
                    end
                end
            end
        end
    end

    // AW payload stability and last cycle with wvalid high
    logic        mon_on = 1'b0;
    logic [31:0] mon_addr = '0;
    int          aw_unstable = 0;
    int          w_last_cyc = -1;
    always @(negedge clk) begin
        if (mon_on) begin
            if (axi_awvalid && axi_awaddr != mon_addr) aw_unstable++;
            if (axi_wvalid) w_last_cyc = cyc;
        end
    end

    // ---------------- checking ----------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request from a negedge, wait for its response and consume it.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rdata,
                          output logic [1:0] resp, output logic err, output int acc_c,
                          output int rsp_c);
        int k;
        rdata = '0; resp = 2'b00; err = 1'b0; acc_c = 0; rsp_c = -100;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
        k = 0;
        while (!req_ready && k < 20) begin
            @(posedge clk); @(negedge clk); k++;
        end
        if (!req_ready) begin
            check_val("accept_timeout", 64'(req_ready), 64'd1);
            req_valid = 1'b0;
            return;
        end
        acc_c = cyc;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 50) begin
            @(posedge clk); @(negedge clk); k++;
        end
        if (!rsp_valid) begin
            check_val("rsp_timeout", 64'(rsp_valid), 64'd1);
            return;
        end
        rsp_c = cyc; rdata = rsp_rdata; resp = rsp_resp; err = rsp_err;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [31:0] rd;
    logic [1:0]  rs;
    logic        er;
    int          acc, rc, wc, k;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_wstrb = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_req_ready", 64'(req_ready), 64'd1);
        check_val("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_val("rst_err_count", 64'(err_count), 64'd0);
        check_val("rst_rsp_resp", 64'(rsp_resp), 64'd0);
        check_val("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check_val("rst_axi_ctl", 64'({axi_awvalid, axi_wvalid, axi_bready, axi_arvalid,
                                       axi_rready}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // zero-wait write
        do_req(1'b1, 32'h400, 32'hdeadbeef, 4'hf, rd, rs, er, acc, rc);
        check_val("wr_aw_lat", 64'(aw_hs_cyc - acc), 64'd1);
        check_val("wr_w_lat", 64'(w_hs_cyc - acc), 64'd1);
        check_val("wr_rsp_lat", 64'(rc - acc), 64'd3);
        check_val("wr_resp", 64'(rs), 64'd0);
        check_val("wr_err", 64'(er), 64'd0);
        check_val("wr_rdata", 64'(rd), 64'd0);
        check_val("wr_count1", 64'(wr_count), 64'd1);

        // read back
        do_req(1'b0, 32'h400, 32'h0, 4'h0, rd, rs, er, acc, rc);
        check_val("rd_ar_lat", 64'(ar_hs_cyc - acc), 64'd1);
        check_val("rd_rsp_lat", 64'(rc - acc), 64'd3);
        check_val("rd_data", 64'(rd), 64'hdeadbeef);
        check_val("rd_resp", 64'(rs), 64'd0);

        // out-of-range read
        do_req(1'b0, 32'h2000, 32'h0, 4'h0, rd, rs, er, acc, rc);
        check_val("bad_resp", 64'(rs), 64'd2);
        check_val("bad_err", 64'(er), 64'd1);
        check_val("bad_rdata", 64'(rd), 64'd0);
        check_val("bad_err_count", 64'(err_count), 64'd1);

        // awready delayed 3 cycles, wready immediate, partial strobe
        aw_delay = 3; mon_addr = 32'h404; mon_on = 1'b1; wc = wr_count;
        do_req(1'b1, 32'h404, 32'h12345678, 4'h3, rd, rs, er, acc, rc);
        mon_on = 1'b0; aw_delay = 0;
        check_val("dly_aw_lat", 64'(aw_hs_cyc - acc), 64'd4);
        check_val("dly_w_lat", 64'(w_hs_cyc - acc), 64'd1);
        check_val("dly_w_last", 64'(w_last_cyc - acc), 64'd1);
        check_val("dly_aw_stable", 64'(aw_unstable), 64'd0);
        check_val("dly_one_write", 64'(wr_count - wc), 64'd1);
        check_val("dly_rsp_lat", 64'(rc - acc), 64'd6);
        check_val("dly_resp", 64'(rs), 64'd0);
        do_req(1'b0, 32'h404, 32'h0, 4'h0, rd, rs, er, acc, rc);
        check_val("strb_rd", 64'(rd), 64'h00005678);

        // wstrb=0 still goes out on the bus, memory unchanged
        wc = wr_count;
        do_req(1'b1, 32'h404, 32'hffffffff, 4'h0, rd, rs, er, acc, rc);
        check_val("strb0_issued", 64'(wr_count - wc), 64'd1);
        do_req(1'b0, 32'h404, 32'h0, 4'h0, rd, rs, er, acc, rc);
        check_val("strb0_rd", 64'(rd), 64'h00005678);

        // response back-pressure with the next request already waiting
        rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h400;
        check_val("bp_accept", 64'(req_ready), 64'd1);
        @(posedge clk); @(negedge clk);
        req_addr = 32'h404;
        k = 0;
        while (!rsp_valid && k < 20) begin
            @(posedge clk); @(negedge clk); k++;
        end
        for (int i = 0; i < 5; i++) begin
            check_val("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            check_val("bp_rsp_rdata", 64'(rsp_rdata), 64'hdeadbeef);
            check_val("bp_rsp_resp", 64'(rsp_resp), 64'd0);
            check_val("bp_req_ready", 64'(req_ready), 64'd0);
            @(posedge clk); @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check_val("bp_next_ready", 64'(req_ready), 64'd1);
        check_val("bp_rsp_drop", 64'(rsp_valid), 64'd0);
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 20) begin
            @(posedge clk); @(negedge clk); k++;
        end
        check_val("bp_next_rdata", 64'(rsp_rdata), 64'h00005678);
        @(posedge clk); @(negedge clk);

        // error counter saturation: 300 error responses in total
        for (int i = 0; i < 299; i++) do_req(1'b0, 32'h2000, 32'h0, 4'h0, rd, rs, er, acc, rc);
        check_val("sat_err_count", 64'(err_count), 64'd255);

        // reset while stalled in RD_RESP
        rd_stall = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h400;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        check_val("rr_arvalid", 64'(axi_arvalid), 64'd1);
        @(posedge clk); @(negedge clk);
        check_val("rr_rready", 64'(axi_rready), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        check_val("rr_axi_ctl", 64'({axi_awvalid, axi_wvalid, axi_bready, axi_arvalid,
                                     axi_rready}), 64'd0);
        check_val("rr_req_ready", 64'(req_ready), 64'd1);
        check_val("rr_rsp_valid", 64'(rsp_valid), 64'd0);
        check_val("rr_err_count", 64'(err_count), 64'd0);
        rst_n = 1'b1; rd_stall = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/axil_mem_master.md
Name: axil_mem_master

Overview:
- AXI4-Lite initiator that converts a simple single-request memory interface from a core or DMA engine into AXI4-Lite read and write transactions.
- Pairs with the team's AXI-Lite RAM responder on the bus side.
- Exactly one transaction is outstanding at a time; the AXI response code is returned to the requester along with the result.

Parameters:
ADDR_WIDTH, 32, width of request and AXI addresses
DATA_WIDTH, 32, data width
STRB_WIDTH, DATA_WIDTH/8, write-strobe width

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
req_valid  in  1  request present
req_ready  out  1  request accepted this cycle when high together with req_valid
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  write data
req_wstrb  in  STRB_WIDTH  write byte enables
rsp_valid  out  1  response present
rsp_ready  in  1  requester consumes response
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_resp  out  2  captured BRESP/RRESP
rsp_err  out  1  rsp_resp[1]
err_count  out  8  saturating count of error responses
axi_awaddr/awvalid/awready, axi_wdata/wstrb/wvalid/wready, axi_bresp/bvalid/bready, axi_araddr/arvalid/arready, axi_rdata/rresp/rvalid/rready  AXI4-Lite master side, standard directions and widths

Behaviour:
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- Reset values: state=IDLE. All valids/readies low. rsp_* = 0, err_count = 0.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr/wdata/wstrb/we. Go to WR_REQ if we=1, otherwise RD_REQ.
  - req_ready=0 in every other state.
- WR_REQ:
  - axi_awvalid and axi_wvalid both rise in the cycle after acceptance, from registers.
  - aw_done and w_done flags track the two handshakes independently. Each valid drops the cycle after its own handshake.
  - Both handshakes in the same cycle is legal and counts as both done.
  - Go to WR_RESP when both are done.
  - Both valids are asserted together on entry. Responders that wait for awvalid&&wvalid must therefore not deadlock.
  - AW/W payloads stay stable while their valid is high.
- WR_RESP: axi_bready=1. On bvalid, capture bresp, set rsp_rdata=0, go to RSP.
- RD_REQ: axi_arvalid=1 until arready, then go to RD_RESP.
- RD_RESP: axi_rready=1. On rvalid, capture rdata and rresp, go to RSP.
- RSP:
  - rsp_valid=1 and rsp_* held stable until rsp_ready, then go to IDLE.
  - The next request can be accepted the cycle after the response is consumed.
- Latency against a zero-wait responder (same-cycle ready, response one cycle later):
  - Accept at cycle 0.
  - AW/W or AR handshake at cycle 1.
  - B or R at cycle 2.
  - rsp_valid at cycle 3.
- err_count increments by 1 on entry to RSP when the response code is SLVERR or DECERR. It saturates at 255.
- wstrb=0 is still issued on the bus; no special casing.
- Unexpected bvalid/rvalid while the corresponding ready is low is ignored. It is not captured.
- rst_n low in any state:
  - Returns to IDLE next edge.
  - Drops all AXI valids/readies and discards the in-flight transaction.
  - The system resets the responder simultaneously.
- Addresses pass through unmodified; no alignment check.

Decomposition:
- Shared package axil_pkg:
  - response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - master state enum axil_mst_state_t.
- No sub-module; single flat module.

Test Plan:
- Write 0x400 data 0xDEADBEEF strb 0xF to a zero-wait RAM responder:
  - AW/W handshake at cycle 1, rsp_valid at cycle 3.
  - rsp_resp=00, rsp_err=0, rsp_rdata=0.
- Read 0x400 after that write -> rsp_rdata=0xDEADBEEF, rsp_resp=00, at cycle 3 after accept.
- Read 0x2000 (responder range 0x400-0xFFF) -> rsp_resp=2'b10, rsp_err=1, rsp_rdata=0, err_count 0->1. Repeat 300 errors -> err_count=255.
- awready delayed 3 cycles, wready immediate:
  - wvalid drops after cycle 1.
  - awvalid and awaddr held stable until the handshake.
  - Exactly one write reaches memory; then WR_RESP.
- rsp_ready low for 5 cycles -> rsp_valid and rsp_* stable; req_ready stays 0 with req_valid high. Next request accepted 1 cycle after rsp_ready.
- rst_n asserted in RD_RESP with the responder stalled -> next cycle all AXI valids/readies 0, req_ready=1, rsp_valid=0, err_count=0.
